// File: rtl/pll_supervisor_pkg.sv
// Shared types and widths for the PLL supervisor.
//   state_e : FSM state encoding, also exported on state_o for debug
//   CNT_W   : width of the shared phase counter
//   LOSS_W  : width of the saturating lock-loss counter
package pll_supervisor_pkg;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned LOSS_W = 8;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

endpackage

// File: rtl/pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its surroundings.
//   pll_locked    : PLL lock indicator, asynchronous to refclk
//   soft_reset    : one-cycle request for a full PLL reset sequence
//   pll_rst       : active-high reset to the PLL
//   sys_rst_n     : active-low reset for downstream clock domains
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   state_o       : current FSM state, for debug
// master drives the requests (system side), slave is the supervisor.
interface pll_supervisor_if;
    import pll_supervisor_pkg::*;

    logic              pll_locked;
    logic              soft_reset;
    logic              pll_rst;
    logic              sys_rst_n;
    logic [LOSS_W-1:0] lock_loss_cnt;
    logic [1:0]        state_o;

    modport master (
        output pll_locked,
        output soft_reset,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_loss_cnt,
        input  state_o
    );

    modport slave (
        input  pll_locked,
        input  soft_reset,
        output pll_rst,
        output sys_rst_n,
        output lock_loss_cnt,
        output state_o
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses the PLL reset, waits for lock, qualifies lock for
// STABLE_CYCLES consecutive cycles, then releases sys_rst_n. Lock loss in RUN
// drops sys_rst_n and restarts qualification; soft_reset forces a new PLL reset.
//   refclk : free-running reference clock, all logic on this clock
//   rst_n  : asynchronous active-low reset
//   bus    : pll_supervisor_if.slave (pll_locked, soft_reset in;
//            pll_rst, sys_rst_n, lock_loss_cnt, state_o out)
// Build option: define PLL_SUPERVISOR_RETRY_EN to re-reset the PLL after
// TIMEOUT_CYCLES in WAIT_LOCK without lock; otherwise WAIT_LOCK waits forever.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned STABLE_CYCLES  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            refclk,
    input  logic            rst_n,
    pll_supervisor_if.slave bus
);

    // Phase lengths must be non-zero and reachable by the counter.
    if (RST_CYCLES == 0 || STABLE_CYCLES == 0 || TIMEOUT_CYCLES == 0 ||
        RST_CYCLES > (1 << CNT_W) || STABLE_CYCLES > (1 << CNT_W) ||
        TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_cfg_check
        $error("pll_supervisor: cycle parameters must lie in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_SUPERVISOR_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              locked_s;
    logic              pll_rst_q;
    logic              sys_rst_n_q;
    logic [LOSS_W-1:0] loss_cnt;

    sync2 u_sync2 (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    // FSM with registered outputs; every transition terminates the counter
    // at its terminal count, so it never wraps.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            loss_cnt    <= '0;
        end else if (bus.soft_reset) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_TC) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end
`ifdef PLL_SUPERVISOR_RETRY_EN
                    else if (cnt == TIMEOUT_TC) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_TC) begin
                        state       <= RUN;
                        cnt         <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        sys_rst_n_q <= 1'b0;
                        if (loss_cnt != {LOSS_W{1'b1}}) begin
                            loss_cnt <= loss_cnt + LOSS_W'(1);
                        end
                    end
                end
                default: begin
                    state <= PLL_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.lock_loss_cnt = loss_cnt;
    assign bus.state_o       = 2'(state);

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor with RST_CYCLES=4, STABLE_CYCLES=16,
// TIMEOUT_CYCLES=100. A phase-level reference model predicts every output
// each cycle; directed scenarios add latency and saturation checks, followed
// by randomized lock/soft-reset/async-reset traffic.
module tb_pll_supervisor;

    localparam int RST_C = 4;
    localparam int STB_C = 16;
    localparam int TO_C  = 100;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_QUAL = 2;
    localparam int M_RUN  = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    pll_supervisor_if bus ();

    pll_supervisor #(
        .RST_CYCLES     (RST_C),
        .STABLE_CYCLES  (STB_C),
        .TIMEOUT_CYCLES (TO_C)
    ) dut (
        .refclk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase, cycles spent in phase, loss count, and the
    // two-cycle delay the lock input sees before the supervisor acts on it.
    int   m_mode;
    int   m_n;
    int   m_loss;
    logic m_dly [2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_mode   = M_RST;
        m_n      = 0;
        m_loss   = 0;
        m_dly[0] = 1'b0;
        m_dly[1] = 1'b0;
    endtask

    task automatic model_edge();
        logic seen;
        seen = m_dly[1];
        if (bus.soft_reset) begin
            m_mode = M_RST;
            m_n    = 0;
        end else if (m_mode == M_RST) begin
            m_n++;
            if (m_n == RST_C) begin m_mode = M_WAIT; m_n = 0; end
        end else if (m_mode == M_WAIT) begin
            if (seen) begin
                m_mode = M_QUAL;
                m_n    = 0;
            end else begin
                m_n++;
`ifdef PLL_SUPERVISOR_RETRY_EN
                if (m_n == TO_C) begin m_mode = M_RST; m_n = 0; end
`endif
            end
        end else if (m_mode == M_QUAL) begin
            if (!seen) begin
                m_mode = M_WAIT;
                m_n    = 0;
            end else begin
                m_n++;
                if (m_n == STB_C) m_mode = M_RUN;
            end
        end else begin
            if (!seen) begin
                m_mode = M_WAIT;
                m_n    = 0;
                if (m_loss < 255) m_loss++;
            end
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = bus.pll_locked;
    endtask

    task automatic compare_all();
        check("pll_rst",       int'(bus.pll_rst),       int'(m_mode == M_RST));
        check("sys_rst_n",     int'(bus.sys_rst_n),     int'(m_mode == M_RUN));
        check("state_o",       int'(bus.state_o),       m_mode);
        check("lock_loss_cnt", int'(bus.lock_loss_cnt), m_loss);
    endtask

    // One clock: model advances on the active edge, outputs compared on the
    // falling edge; inputs are changed by the caller after this returns.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, released
    // on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // which 0: wait for sys_rst_n high; which 1: wait for state STABLE.
    task automatic wait_for(input int which, input int budget, input string tag);
        int  k;
        logic hit;
        k   = 0;
        hit = (which == 0) ? (bus.sys_rst_n === 1'b1) : (bus.state_o === 2'd2);
        while (!hit && k < budget) begin
            step();
            k++;
            hit = (which == 0) ? (bus.sys_rst_n === 1'b1) : (bus.state_o === 2'd2);
        end
        check(tag, int'(hit), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int rise;
        int fell;
        int k;
        int pulses;
        int hold;
        logic prev;

        rst_n          = 1'b0;
        bus.pll_locked = 1'b1;
        bus.soft_reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Boot with lock already present: sync latency hides under the reset
        // pulse, so release = RST_C + 1 (WAIT_LOCK sees lock) + STB_C edges.
        hi   = int'(bus.pll_rst);
        rise = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.pll_rst) hi++;
            if (rise < 0 && bus.sys_rst_n) rise = c;
        end
        check("boot_pll_rst_len", hi, RST_C);
        check("boot_release_cycle", rise, RST_C + 1 + STB_C);
        check("boot_loss_cnt", int'(bus.lock_loss_cnt), 0);

        // Lock lost for 3 cycles in RUN.
        bus.pll_locked = 1'b0;
        fell = -1;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (fell < 0 && !bus.sys_rst_n) fell = c;
        end
        check("drop_latency", fell, 3);
        bus.pll_locked = 1'b1;
        k = 0;
        while (!bus.sys_rst_n && k < 60) begin step(); k++; end
        check("requal_latency", k, 2 + 1 + STB_C);
        check("loss_after_drop", int'(bus.lock_loss_cnt), 1);

        // Soft reset in RUN.
        bus.soft_reset = 1'b1;
        step();
        bus.soft_reset = 1'b0;
        check("soft_state", int'(bus.state_o), 0);
        check("soft_sys_rst_n", int'(bus.sys_rst_n), 0);
        check("soft_pll_rst", int'(bus.pll_rst), 1);

        // One-cycle glitch at qualification cycle 10 restarts the full count.
        wait_for(1, 40, "reach_stable");
        k = 0;
        repeat (10) begin step(); k++; end
        bus.pll_locked = 1'b0;
        step(); k++;
        bus.pll_locked = 1'b1;
        while (!bus.sys_rst_n && k < 80) begin
            step(); k++;
            if (k == STB_C) check("glitch_no_release", int'(bus.sys_rst_n), 0);
        end
        check("glitch_restart", k, 10 + 1 + 1 + 1 + 1 + STB_C);

        // 300 lock losses: counter saturates.
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b0;
            step();
            bus.pll_locked = 1'b1;
            repeat (3) step();
            wait_for(0, 60, "loss_loop_release");
        end
        check("loss_saturated", int'(bus.lock_loss_cnt), 255);

        // No lock at all after a soft reset: retry pulses or a single pulse.
        bus.pll_locked = 1'b0;
        bus.soft_reset = 1'b1;
        prev   = bus.pll_rst;
        pulses = 0;
        hi     = 0;
        for (int c = 1; c <= 520; c++) begin
            step();
            bus.soft_reset = 1'b0;
            if (bus.pll_rst && !prev) pulses++;
            if (bus.pll_rst) hi++;
            prev = bus.pll_rst;
        end
`ifdef PLL_SUPERVISOR_RETRY_EN
        check("nolock_pulses", pulses, (520 - 1) / (RST_C + TO_C) + 1);
        check("nolock_high_cycles", hi, ((520 - 1) / (RST_C + TO_C) + 1) * RST_C);
`else
        check("nolock_pulses", pulses, 1);
        check("nolock_high_cycles", hi, RST_C);
`endif

        // Async reset while qualifying: no partial release.
        bus.pll_locked = 1'b1;
        wait_for(1, 40, "reach_stable_2");
        repeat (5) step();
        do_reset();
        check("abort_sys_rst_n", int'(bus.sys_rst_n), 0);

        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                bus.pll_locked = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 40);
            end
            hold--;
            bus.soft_reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
            step();
        end
        bus.soft_reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
